// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: ALU op codes, instruction fields,
// state encodings, mux selects and the per-state Moore output table.
package mc_ctrl_pkg;

  // ALU operation select, shared with the ALU itself
  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluAnd = 3'b001,
    AluXor = 3'b010,
    AluSub = 3'b100,
    AluOr  = 3'b101,
    AluLui = 3'b110
  } alu_op_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StRExe    = 4'd3,
    StRWb     = 4'd4,
    StIExe    = 4'd5,
    StIWb     = 4'd6,
    StMemAddr = 4'd7,
    StMemRd   = 4'd8,
    StMemWb   = 4'd9,
    StMemWr   = 4'd10,
    StBranch  = 4'd11,
    StJump    = 4'd12,
    StHalt    = 4'd13
  } state_e;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBBrOff = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    alu_op_e    alu_op;
    logic       illegal;
  } ctrl_t;

  // Moore outputs for a state; the mem_ack/zero dependent enables are added by the caller
  function automatic ctrl_t state_ctrl(state_e st, alu_op_e dec_op, logic dec_ext);
    ctrl_t c;
    c        = '0;
    c.alu_op = AluAdd;
    case (st)
      StFetch: begin
        c.mem_rd    = 1'b1;
        c.alu_src_b = SrcBFour;
        c.pc_src    = PcSrcAlu;
      end
      StDecode: c.alu_src_b = SrcBBrOff;
      StRExe: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
        c.alu_op    = dec_op;
      end
      StRWb: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 1'b1;
      end
      StIExe: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
        c.alu_op    = dec_op;
        c.ext_zero  = dec_ext;
      end
      StIWb: c.reg_we = 1'b1;
      StMemAddr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        c.mem_rd = 1'b1;
        c.iord   = 1'b1;
      end
      StMemWb: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        c.mem_wr = 1'b1;
        c.iord   = 1'b1;
      end
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
        c.alu_op    = AluSub;
        c.pc_src    = PcSrcAluOut;
      end
      StJump: begin
        c.pc_we  = 1'b1;
        c.pc_src = PcSrcJump;
      end
      StHalt:  c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decode: ALU operation, immediate extension mode and legality.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic       ext_zero,
  output logic       legal
);

  always_comb begin
    alu_op   = AluAdd;
    ext_zero = 1'b0;
    legal    = 1'b0;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd: begin alu_op = AluAdd; legal = 1'b1; end
          FnSub: begin alu_op = AluSub; legal = 1'b1; end
          FnAnd: begin alu_op = AluAnd; legal = 1'b1; end
          FnOr:  begin alu_op = AluOr;  legal = 1'b1; end
          FnXor: begin alu_op = AluXor; legal = 1'b1; end
          default: ;
        endcase
      end
      OpAddi: legal = 1'b1;
      OpAndi: begin alu_op = AluAnd; ext_zero = 1'b1; legal = 1'b1; end
      OpOri:  begin alu_op = AluOr;  ext_zero = 1'b1; legal = 1'b1; end
      OpXori: begin alu_op = AluXor; ext_zero = 1'b1; legal = 1'b1; end
      OpLui:  begin alu_op = AluLui; ext_zero = 1'b1; legal = 1'b1; end
      OpLw, OpSw, OpBeq, OpJ: legal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control unit: Moore FSM with registered outputs and a req/ack memory
// handshake; only ir_we/pc_we see mem_ack (FETCH) and zero (BRANCH) combinationally.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_e  state_q, state_d;
  ctrl_t   ctrl_q;
  alu_op_e dec_op;
  logic    dec_ext;
  logic    dec_legal;
  logic    in_fetch;
  logic    in_branch;

  mc_alu_dec u_alu_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_op),
    .ext_zero (dec_ext),
    .legal    (dec_legal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (mem_ack) state_d = StDecode;
      StDecode: begin
        if (!dec_legal) begin
          state_d = StHalt;
        end else begin
          case (opcode)
            OpRtype:    state_d = StRExe;
            OpLw, OpSw: state_d = StMemAddr;
            OpBeq:      state_d = StBranch;
            OpJ:        state_d = StJump;
            default:    state_d = StIExe;
          endcase
        end
      end
      StRExe:    state_d = StRWb;
      StRWb:     state_d = StFetch;
      StIExe:    state_d = StIWb;
      StIWb:     state_d = StFetch;
      StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ack) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (mem_ack) state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they are valid for the whole state cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d, dec_op, dec_ext);
    end
  end

  assign in_fetch  = (state_q == StFetch);
  assign in_branch = (state_q == StBranch);

  assign mem_rd     = ctrl_q.mem_rd;
  assign mem_wr     = ctrl_q.mem_wr;
  assign iord       = ctrl_q.iord;
  assign ir_we      = in_fetch & mem_ack;
  assign pc_we      = ctrl_q.pc_we | (in_fetch & mem_ack) | (in_branch & zero);
  assign pc_src     = ctrl_q.pc_src;
  assign reg_we     = ctrl_q.reg_we;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign ext_zero   = ctrl_q.ext_zero;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal    = ctrl_q.illegal;
  assign state      = state_q;

  mem_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_rd && mem_wr));

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed table, hand-written reset/halt sequences and
// random instruction streams checked cycle by cycle against an instruction-level model.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ack;
  logic       mem_rd, mem_wr, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic       ext_zero, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ack    (mem_ack),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_zero   (ext_zero),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_rd, mem_wr, iord, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic       illegal;
  } obs_t;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    bit         z;
    int         fw, mw;
    int         cycles;
    int         exe_op;
    int         ext;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t exp_q[$];
  bit   ack_q[$];
  bit   zero_q[$];
  bit   model_halts;
  int   cap_op, cap_ext, cap_irwe;

  function automatic obs_t dut_obs();
    obs_t o;
    o.st = state; o.mem_rd = mem_rd; o.mem_wr = mem_wr; o.iord = iord; o.ir_we = ir_we;
    o.pc_we = pc_we; o.pc_src = pc_src; o.reg_we = reg_we; o.reg_dst = reg_dst;
    o.mem_to_reg = mem_to_reg; o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.ext_zero = ext_zero; o.alu_op = alu_op; o.illegal = illegal;
    return o;
  endfunction

  function automatic obs_t blank(logic [3:0] st);
    obs_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_obs(string name, int cyc, obs_t got, obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h required %h", name, cyc, got, exp);
  endtask

  task automatic check_val(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  task automatic push(obs_t o, bit a, bit z);
    exp_q.push_back(o);
    ack_q.push_back(a);
    zero_q.push_back(z);
  endtask

  // Instruction-level reference: expected cycle-by-cycle outputs plus input schedule
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input bit z,
                       input int fw, input int mw);
    obs_t       o;
    logic [2:0] xop;
    bit         xext;
    int         kind;  // 0 R, 1 I, 2 lw, 3 sw, 4 beq, 5 j, 6 illegal
    exp_q.delete(); ack_q.delete(); zero_q.delete();
    model_halts = 1'b0;
    kind = 6; xop = 3'b000; xext = 1'b0;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: begin kind = 0; xop = 3'b000; end
          6'b100010: begin kind = 0; xop = 3'b100; end
          6'b100100: begin kind = 0; xop = 3'b001; end
          6'b100101: begin kind = 0; xop = 3'b101; end
          6'b100110: begin kind = 0; xop = 3'b010; end
          default:   kind = 6;
        endcase
      end
      6'b001000: begin kind = 1; xop = 3'b000; end
      6'b001100: begin kind = 1; xop = 3'b001; xext = 1'b1; end
      6'b001101: begin kind = 1; xop = 3'b101; xext = 1'b1; end
      6'b001110: begin kind = 1; xop = 3'b010; xext = 1'b1; end
      6'b001111: begin kind = 1; xop = 3'b110; xext = 1'b1; end
      6'b100011: kind = 2;
      6'b101011: kind = 3;
      6'b000100: kind = 4;
      6'b000010: kind = 5;
      default:   kind = 6;
    endcase
    for (int k = 0; k < fw; k++) begin
      o = blank(StFetch); o.mem_rd = 1'b1; o.alu_src_b = 2'b01;
      push(o, 1'b0, rb());
    end
    o = blank(StFetch); o.mem_rd = 1'b1; o.alu_src_b = 2'b01; o.ir_we = 1'b1; o.pc_we = 1'b1;
    push(o, 1'b1, rb());
    o = blank(StDecode); o.alu_src_b = 2'b11;
    push(o, rb(), rb());
    case (kind)
      0: begin
        o = blank(StRExe); o.alu_src_a = 1'b1; o.alu_op = xop; push(o, rb(), rb());
        o = blank(StRWb); o.reg_we = 1'b1; o.reg_dst = 1'b1; push(o, rb(), rb());
      end
      1: begin
        o = blank(StIExe); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = xop;
        o.ext_zero = xext; push(o, rb(), rb());
        o = blank(StIWb); o.reg_we = 1'b1; push(o, rb(), rb());
      end
      2, 3: begin
        o = blank(StMemAddr); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; push(o, rb(), rb());
        if (kind == 2) begin o = blank(StMemRd); o.mem_rd = 1'b1; end
        else begin o = blank(StMemWr); o.mem_wr = 1'b1; end
        o.iord = 1'b1;
        for (int k = 0; k < mw; k++) push(o, 1'b0, rb());
        push(o, 1'b1, rb());
        if (kind == 2) begin
          o = blank(StMemWb); o.reg_we = 1'b1; o.mem_to_reg = 1'b1; push(o, rb(), rb());
        end
      end
      4: begin
        o = blank(StBranch); o.alu_src_a = 1'b1; o.alu_op = 3'b100; o.pc_src = 2'b01;
        o.pc_we = z; push(o, rb(), z);
      end
      5: begin
        o = blank(StJump); o.pc_we = 1'b1; o.pc_src = 2'b10; push(o, rb(), rb());
      end
      default: begin
        model_halts = 1'b1;
        o = blank(StHalt); o.illegal = 1'b1;
        for (int k = 0; k < 12; k++) push(o, rb(), rb());
      end
    endcase
  endtask

  // Entered at posedge+1 with the DUT in FETCH; returns once the next FETCH starts
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input int fw, input int mw, output int cycles);
    int len, cyc;
    bit seen, done;
    model(op, fn, z, fw, mw);
    len = exp_q.size();
    opcode = op; funct = fn;
    cyc = 0; seen = 1'b0; done = 1'b0;
    cap_op = 0; cap_ext = 0; cap_irwe = 0;
    while (!done && cyc < 40) begin
      if (!model_halts && seen && state == StFetch) begin
        done = 1'b1;
      end else begin
        if (state != StFetch) seen = 1'b1;
        if (cyc < len) begin mem_ack = ack_q[cyc]; zero = zero_q[cyc]; end
        else begin mem_ack = 1'b0; zero = 1'b0; end
        @(negedge clk);
        if (state == StRExe || state == StIExe || state == StMemAddr || state == StBranch) begin
          cap_op = int'(alu_op); cap_ext = int'(ext_zero);
        end
        if (ir_we) cap_irwe++;
        if (cyc < len) check_obs(name, cyc, dut_obs(), exp_q[cyc]);
        else check_val({name, " overrun state"}, int'(state), int'(StFetch));
        @(posedge clk); #1;
        cyc++;
        if (model_halts && cyc == len) done = 1'b1;
      end
    end
    if (!done) check_val({name, " retire timeout"}, cyc, len);
    else if (!model_halts) check_val({name, " length"}, cyc, len);
    cycles = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ack = 1'b0; zero = 1'b0;
    #1;
    check_obs("reset", 0, dut_obs(), blank(StIdle));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_obs("idle after reset", 0, dut_obs(), blank(StIdle));
    @(posedge clk); #1;
  endtask

  vec_t        tbl[12];
  logic [11:0] legal_ops[14];

  function automatic vec_t mkv(string name, logic [5:0] op, logic [5:0] fn, bit z, int fw,
                               int mw, int cycles, int exe_op, int ext);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.z = z; v.fw = fw; v.mw = mw;
    v.cycles = cycles; v.exe_op = exe_op; v.ext = ext;
    return v;
  endfunction

  initial begin
    int   cyc, wait_cnt;
    obs_t ho;
    tbl[0]  = mkv("add",      6'h00, 6'h20, 1'b0, 0, 0, 4, 3'b000, 0);
    tbl[1]  = mkv("sub",      6'h00, 6'h22, 1'b0, 0, 0, 4, 3'b100, 0);
    tbl[2]  = mkv("xor",      6'h00, 6'h26, 1'b1, 0, 0, 4, 3'b010, 0);
    tbl[3]  = mkv("lw waits", 6'h23, 6'h11, 1'b0, 2, 2, 9, 3'b000, 0);
    tbl[4]  = mkv("sw wait",  6'h2b, 6'h00, 1'b0, 0, 1, 5, 3'b000, 0);
    tbl[5]  = mkv("beq z1",   6'h04, 6'h00, 1'b1, 0, 0, 3, 3'b100, 0);
    tbl[6]  = mkv("beq z0",   6'h04, 6'h00, 1'b0, 0, 0, 3, 3'b100, 0);
    tbl[7]  = mkv("j",        6'h02, 6'h3f, 1'b0, 0, 0, 3, 3'b000, 0);
    tbl[8]  = mkv("ori",      6'h0d, 6'h20, 1'b0, 0, 0, 4, 3'b101, 1);
    tbl[9]  = mkv("lui",      6'h0f, 6'h00, 1'b0, 0, 0, 4, 3'b110, 1);
    tbl[10] = mkv("addi",     6'h08, 6'h24, 1'b0, 0, 0, 4, 3'b000, 0);
    tbl[11] = mkv("andi wait", 6'h0c, 6'h00, 1'b0, 1, 0, 5, 3'b001, 1);
    legal_ops = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25},
                  {6'h00, 6'h26}, {6'h08, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00},
                  {6'h0e, 6'h00}, {6'h0f, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00},
                  {6'h04, 6'h00}, {6'h02, 6'h00}};
    opcode = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0; rst_n = 1'b1;
    #2;
    do_reset();

    foreach (tbl[i]) begin
      run_instr(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].fw, tbl[i].mw, cyc);
      check_val({tbl[i].name, " cycles"}, cyc, tbl[i].cycles);
      check_val({tbl[i].name, " exe alu_op"}, cap_op, tbl[i].exe_op);
      check_val({tbl[i].name, " exe ext_zero"}, cap_ext, tbl[i].ext);
      check_val({tbl[i].name, " ir_we pulses"}, cap_irwe, 1);
    end

    // Illegal opcode, then illegal R-type funct: HALT is sticky until reset
    run_instr("halt opcode", 6'h3f, 6'h20, 1'b0, 0, 0, cyc);
    ho = blank(StHalt); ho.illegal = 1'b1;
    mem_ack = 1'b1; zero = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_obs("halt sticky", 0, dut_obs(), ho);
    do_reset();
    run_instr("halt funct", 6'h00, 6'h2a, 1'b0, 1, 0, cyc);
    do_reset();

    // Reset asserted while a store waits in MEM_WR
    opcode = 6'h2b; funct = 6'h00; zero = 1'b0;
    wait_cnt = 0;
    while (state != StMemWr && wait_cnt < 10) begin
      mem_ack = (state == StFetch);
      @(posedge clk); #1;
      wait_cnt++;
    end
    mem_ack = 1'b0;
    check_val("reach MEM_WR", int'(state), int'(StMemWr));
    @(negedge clk);
    check_val("mem_wr before reset", int'(mem_wr), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_obs("async reset in MEM_WR", 0, dut_obs(), blank(StIdle));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_obs("idle after release", 0, dut_obs(), blank(StIdle));
    @(posedge clk); #1;
    check_val("fetch after idle", int'(state), int'(StFetch));

    // Random instruction stream with random memory waits
    for (int n = 0; n < 200; n++) begin
      logic [11:0] pick;
      logic [5:0]  op, fn;
      if ($urandom_range(0, 19) == 0) begin
        op = 6'($urandom); fn = 6'($urandom);
      end else begin
        pick = legal_ops[$urandom_range(0, 13)];
        op = pick[11:6];
        fn = (op == 6'h00) ? pick[5:0] : 6'($urandom);
      end
      run_instr("random", op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3), cyc);
      if (model_halts) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the lab CPU datapath. It sits directly upstream of the ALU and drives its 3-bit operation select and operand muxes. It also drives the PC, IR, register-file and memory enables for one instruction at a time, using a Moore state machine with a req/ack memory handshake. Supported instructions are R-type add/sub/and/or/xor, addi/andi/ori/xori/lui, lw, sw, beq and j; any other encoding halts the controller.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction retires
- funct  in  6  IR[5:0]
- zero  in  1  ALU Zero flag
- mem_ack  in  1  memory completes the pending access this cycle
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  IR load
- pc_we  out  1  PC load
- pc_src  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- reg_we  out  1  register-file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = extended imm, 11 = sign-ext imm<<2
- ext_zero  out  1  1 = zero-extend imm (andi/ori/xori/lui), 0 = sign-extend
- alu_op  out  3  ADD 000, SUB 100, AND 001, OR 101, XOR 010, LUI 110
- illegal  out  1  high while in HALT
- state  out  4  current state encoding, for debug

## Operation
- Outputs not listed for a state are 0, and alu_op is ADD.
- **IDLE** (code 0, reset state): all outputs 0; next state FETCH.
- **FETCH**:
  - Outputs: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - ir_we = pc_we = mem_ack (Mealy).
  - Stay while mem_ack=0; go to DECODE on mem_ack=1.
- **DECODE**:
  - Outputs: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut).
  - Next state by opcode:
    - 000000 with legal funct (100000/100010/100100/100101/100110) → R_EXE
    - 100011 or 101011 → MEM_ADDR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 / 001100 / 001101 / 001110 / 001111 → I_EXE
    - anything else → HALT
- **R_EXE**: alu_src_a=1, alu_src_b=00, alu_op from funct (add→ADD, sub→SUB, and→AND, or→OR, xor→XOR); next R_WB.
- **R_WB**: reg_we=1, reg_dst=1, mem_to_reg=0; next FETCH.
- **I_EXE**:
  - alu_src_a=1, alu_src_b=10.
  - alu_op: addi→ADD, andi→AND, ori→OR, xori→XOR, lui→LUI.
  - ext_zero=1 for all except addi.
  - Next I_WB.
- **I_WB**: reg_we=1, reg_dst=0, mem_to_reg=0; next FETCH.
- **MEM_ADDR**: alu_src_a=1, alu_src_b=10, ADD, ext_zero=0; next MEM_RD for lw, MEM_WR for sw.
- **MEM_RD**: mem_rd=1, iord=1; stay until mem_ack, then MEM_WB.
- **MEM_WB**: reg_we=1, reg_dst=0, mem_to_reg=1; next FETCH.
- **MEM_WR**: mem_wr=1, iord=1; stay until mem_ack, then FETCH.
- **BRANCH**: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_we=zero; next FETCH.
- **JUMP**: pc_we=1, pc_src=10; next FETCH.
- **HALT**: all enables 0, illegal=1; stays in HALT until reset.
- mem_ack is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- mem_rd and mem_wr are never high together.

## Timing
- With zero-wait memory (mem_ack high on the first request cycle), cycles per instruction:
  - R-type 4
  - I-type 4
  - lw 5
  - sw 4
  - beq 3
  - j 3
- Each cycle mem_ack stays low adds exactly one cycle in that state, with all outputs held.
- First FETCH begins one cycle after rst_n deasserts (IDLE occupies that cycle).
- Reset asserted mid-instruction:
  - state goes to IDLE asynchronously;
  - every output drops to 0 without waiting for a clock edge;
  - illegal clears.
- Outputs are a function of state only, except ir_we/pc_we in FETCH (mem_ack) and pc_we in BRANCH (zero).

## Structure
- Shared include/package holds:
  - the ALU op codes, identical to the ALU's definitions;
  - opcode and funct constants;
  - state encodings;
  - alu_src_b and pc_src encodings.
- The ALU consumes the same op-code definitions.
- Sub-module mc_alu_dec: combinational opcode/funct → alu_op, ext_zero, legal.
  - mc_ctrl instantiates it once.
  - The legal flag is used in DECODE.

## Test plan
- add (opcode 0, funct 100000), mem_ack always 1 → states FETCH, DECODE, R_EXE, R_WB; alu_op=000 in R_EXE; reg_we=1 and reg_dst=1 in R_WB; 4 cycles total.
- lw with mem_ack low for 2 cycles in both FETCH and MEM_RD → 9 cycles; ir_we pulses for exactly one cycle; reg_we=1 and mem_to_reg=1 in MEM_WB.
- beq with zero=1, then beq with zero=0 → pc_we=1, pc_src=01 in BRANCH for the first; pc_we=0 for the second; both take 3 cycles.
- ori, then lui → alu_op 101 and 110 respectively, ext_zero=1; addi → alu_op 000, ext_zero=0.
- opcode 111111, then R-type funct 101010 → HALT; illegal=1; all enables 0 for 10+ cycles.
- rst_n pulled low during MEM_WR with mem_wr=1 → mem_wr=0 and state=0 immediately; IDLE, then FETCH after release.
